// File: rtl/car_alarm_chime_driver_if.sv
// Alarm-side signal bundle between the alarm detector/tester (master) and the
// cabin chime driver (slave).
interface car_alarm_chime_driver_if;
    logic       CarAlarmSignal;
    logic       AckButton;
    logic       BuzzerOut;
    logic       WarningLamp;
    logic       ChimeActive;
    logic [7:0] BurstCount;

    modport master (
        output CarAlarmSignal,
        output AckButton,
        input  BuzzerOut,
        input  WarningLamp,
        input  ChimeActive,
        input  BurstCount
    );

    modport slave (
        input  CarAlarmSignal,
        input  AckButton,
        output BuzzerOut,
        output WarningLamp,
        output ChimeActive,
        output BurstCount
    );
endinterface

// File: rtl/car_alarm_chime_driver.sv
// Debounced, pulsed buzzer driver with warning lamp and driver-acknowledge silence.
// Optional macro CHIME_TIMEOUT_EN: auto-silence after MAX_BURSTS completed bursts.
module car_alarm_chime_driver #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned ON_CYCLES       = 8,
    parameter int unsigned OFF_CYCLES      = 8,
    parameter int unsigned MAX_BURSTS      = 6
) (
    input  logic                      clk,
    input  logic                      reset,
    car_alarm_chime_driver_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        QUALIFY  = 3'd1,
        BEEP_ON  = 3'd2,
        BEEP_OFF = 3'd3,
        SILENCED = 3'd4
    } state_e;

    localparam logic [15:0] DEB_LAST = 16'(DEBOUNCE_CYCLES - 1);
    localparam logic [15:0] ON_LAST  = 16'(ON_CYCLES - 1);
    localparam logic [15:0] OFF_LAST = 16'(OFF_CYCLES - 1);

    // Reject out-of-range configurations at elaboration time.
    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535 ||
        ON_CYCLES < 1 || ON_CYCLES > 65535 ||
        OFF_CYCLES < 1 || OFF_CYCLES > 65535 ||
        MAX_BURSTS < 1 || MAX_BURSTS > 255) begin : g_param_check
        $error("car_alarm_chime_driver: parameter out of range");
    end

    state_e      state_q, state_d;
    logic [15:0] qual_q, qual_d;
    logic [15:0] phase_q, phase_d;
    logic [7:0]  burst_q, burst_d;
    logic [7:0]  burst_inc;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            qual_q  <= '0;
            phase_q <= '0;
            burst_q <= '0;
        end else begin
            state_q <= state_d;
            qual_q  <= qual_d;
            phase_q <= phase_d;
            burst_q <= burst_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        qual_d    = qual_q;
        phase_d   = phase_q;
        burst_d   = burst_q;
        burst_inc = sat_inc8(burst_q);
        case (state_q)
            IDLE: begin
                qual_d  = '0;
                phase_d = '0;
                burst_d = '0;
                if (bus.CarAlarmSignal) begin
                    if (DEB_LAST == 16'd0) begin
                        state_d = BEEP_ON;
                    end else begin
                        state_d = QUALIFY;
                        qual_d  = 16'd1;
                    end
                end
            end
            QUALIFY: begin
                if (!bus.CarAlarmSignal) begin
                    state_d = IDLE;
                    qual_d  = '0;
                end else if (qual_q == DEB_LAST) begin
                    state_d = BEEP_ON;
                    qual_d  = '0;
                    phase_d = '0;
                    burst_d = '0;
                end else begin
                    qual_d = qual_q + 16'd1;
                end
            end
            BEEP_ON, BEEP_OFF: begin
                // Alarm drop outranks acknowledge, which outranks sequencing.
                if (!bus.CarAlarmSignal) begin
                    state_d = IDLE;
                    phase_d = '0;
                    burst_d = '0;
                end else if (bus.AckButton) begin
                    state_d = SILENCED;
                    phase_d = '0;
                end else if (state_q == BEEP_ON) begin
                    if (phase_q == ON_LAST) begin
                        state_d = BEEP_OFF;
                        phase_d = '0;
                    end else begin
                        phase_d = phase_q + 16'd1;
                    end
                end else if (phase_q == OFF_LAST) begin
                    phase_d = '0;
                    burst_d = burst_inc;
`ifdef CHIME_TIMEOUT_EN
                    state_d = (burst_inc == 8'(MAX_BURSTS)) ? SILENCED : BEEP_ON;
`else
                    state_d = BEEP_ON;
`endif
                end else begin
                    phase_d = phase_q + 16'd1;
                end
            end
            SILENCED: begin
                if (!bus.CarAlarmSignal) begin
                    state_d = IDLE;
                    burst_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                qual_d  = '0;
                phase_d = '0;
                burst_d = '0;
            end
        endcase
    end

    always_comb begin
        bus.BuzzerOut   = (state_q == BEEP_ON);
        bus.ChimeActive = (state_q == BEEP_ON) || (state_q == BEEP_OFF);
        bus.WarningLamp = (state_q == BEEP_ON) || (state_q == BEEP_OFF) ||
                          (state_q == SILENCED);
        bus.BurstCount  = burst_q;
    end

endmodule

// File: tb/tb_car_alarm_chime_driver.sv
// Directed bench for the chime driver: default-parameter instance plus a 1/1/1 instance.
module tb_car_alarm_chime_driver;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    car_alarm_chime_driver_if bus_a ();
    car_alarm_chime_driver_if bus_b ();

    car_alarm_chime_driver u_dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a.slave)
    );

    car_alarm_chime_driver #(
        .DEBOUNCE_CYCLES (1),
        .ON_CYCLES       (1),
        .OFF_CYCLES      (1),
        .MAX_BURSTS      (6)
    ) u_dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Check buzzer, lamp, chime-active and burst count of instance A together.
    task automatic chk_a(input string tag, input logic buz, input logic lamp,
                         input logic act, input logic [7:0] cnt);
        chk({tag, ".buzzer"}, {7'd0, bus_a.BuzzerOut},   {7'd0, buz});
        chk({tag, ".lamp"},   {7'd0, bus_a.WarningLamp}, {7'd0, lamp});
        chk({tag, ".active"}, {7'd0, bus_a.ChimeActive}, {7'd0, act});
        chk({tag, ".count"},  bus_a.BurstCount,          cnt);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        bus_a.CarAlarmSignal = 1'b0;
        bus_a.AckButton      = 1'b0;
        bus_b.CarAlarmSignal = 1'b0;
        bus_b.AckButton      = 1'b0;
        tick(2);
        chk_a("reset", 1'b0, 1'b0, 1'b0, 8'd0);
        chk("reset_b.buzzer", {7'd0, bus_b.BuzzerOut}, 8'd0);
        reset = 1'b0;

        // Glitch during qualification restarts the debounce.
        bus_a.CarAlarmSignal = 1'b1;
        tick(3);
        chk_a("qual3", 1'b0, 1'b0, 1'b0, 8'd0);
        bus_a.CarAlarmSignal = 1'b0;
        tick();
        chk_a("glitch", 1'b0, 1'b0, 1'b0, 8'd0);
        bus_a.CarAlarmSignal = 1'b1;
        tick(3);
        chk_a("requal3", 1'b0, 1'b0, 1'b0, 8'd0);
        tick();
        chk_a("beep1_start", 1'b1, 1'b1, 1'b1, 8'd0);

        // 8 high / 8 low burst shape.
        for (int i = 1; i < 8; i++) begin
            tick();
            chk("on_phase", {7'd0, bus_a.BuzzerOut}, 8'd1);
        end
        tick();
        chk_a("off1_start", 1'b0, 1'b1, 1'b1, 8'd0);
        for (int i = 1; i < 8; i++) begin
            tick();
            chk("off_phase", {7'd0, bus_a.BuzzerOut}, 8'd0);
        end
        tick();
        chk_a("beep2_start", 1'b1, 1'b1, 1'b1, 8'd1);

        for (int b = 2; b <= 6; b++) begin
            tick(16);
            chk("burst_count", bus_a.BurstCount, 8'(b));
        end
`ifdef CHIME_TIMEOUT_EN
        chk_a("timeout", 1'b0, 1'b1, 1'b0, 8'd6);
`else
        chk_a("burst7", 1'b1, 1'b1, 1'b1, 8'd6);
`endif
        bus_a.CarAlarmSignal = 1'b0;
        tick();
        chk_a("drop_after_bursts", 1'b0, 1'b0, 1'b0, 8'd0);

        // Acknowledge mid-burst 2.
        bus_a.CarAlarmSignal = 1'b1;
        tick(4);
        tick(16);
        chk_a("ack_pre", 1'b1, 1'b1, 1'b1, 8'd1);
        tick(2);
        bus_a.AckButton = 1'b1;
        tick();
        bus_a.AckButton = 1'b0;
        chk_a("ack_silenced", 1'b0, 1'b1, 1'b0, 8'd1);
        tick(3);
        chk_a("silenced_hold", 1'b0, 1'b1, 1'b0, 8'd1);
        bus_a.CarAlarmSignal = 1'b0;
        tick();
        chk_a("silenced_drop", 1'b0, 1'b0, 1'b0, 8'd0);

        // Alarm drop and ack together in BEEP_OFF: drop wins.
        bus_a.CarAlarmSignal = 1'b1;
        tick(4);
        tick(16);
        tick(10);
        chk_a("off2_mid", 1'b0, 1'b1, 1'b1, 8'd1);
        bus_a.CarAlarmSignal = 1'b0;
        bus_a.AckButton      = 1'b1;
        tick();
        bus_a.AckButton = 1'b0;
        chk_a("drop_and_ack", 1'b0, 1'b0, 1'b0, 8'd0);

        // Reset mid-BEEP_ON with alarm held.
        bus_a.CarAlarmSignal = 1'b1;
        tick(4);
        tick(3);
        chk_a("pre_reset", 1'b1, 1'b1, 1'b1, 8'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_a("mid_reset", 1'b0, 1'b0, 1'b0, 8'd0);
        tick(3);
        chk_a("post_reset_qual", 1'b0, 1'b0, 1'b0, 8'd0);
        tick();
        chk_a("post_reset_beep", 1'b1, 1'b1, 1'b1, 8'd0);
        bus_a.CarAlarmSignal = 1'b0;
        tick();

        // Minimal-timing instance: buzzer toggles every cycle.
        bus_b.CarAlarmSignal = 1'b1;
        tick();
        chk("b_first", {7'd0, bus_b.BuzzerOut}, 8'd1);
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk("b_off", {7'd0, bus_b.BuzzerOut}, 8'd0);
            chk("b_off_active", {7'd0, bus_b.ChimeActive}, 8'd1);
            tick();
            chk("b_on", {7'd0, bus_b.BuzzerOut}, 8'd1);
            chk("b_count", bus_b.BurstCount, 8'(k));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/car_alarm_chime_driver.md
# car_alarm_chime_driver

Consumer end of the car alarm interface: takes the level `CarAlarmSignal` produced by the alarm detector (behavioral or gate-level) and drives the in-cabin buzzer with a debounced, pulsed chime pattern, a warning lamp, and a driver-acknowledge silence function. It sits between the alarm detector output and the cabin annunciator pins, and is exercised by the same tester-style testbench flow as the detector.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 4, consecutive high samples of `CarAlarmSignal` required before chiming (1..65535)
- `ON_CYCLES`, 8, buzzer-on length of one burst (1..65535)
- `OFF_CYCLES`, 8, buzzer-off gap after each burst (1..65535)
- `MAX_BURSTS`, 6, bursts before automatic silence, used only with `CHIME_TIMEOUT_EN` (1..255)

Ports:
- `clk`  input  1  single clock; all state changes on its rising edge
- `reset`  input  1  synchronous, active-high reset
- `CarAlarmSignal`  input  1  alarm request level from detector
- `AckButton`  input  1  driver acknowledge; silences the buzzer for the current alarm episode
- `BuzzerOut`  output  1  buzzer drive, high during burst-on phase
- `WarningLamp`  output  1  high while an alarm episode is qualified (chiming or silenced)
- `ChimeActive`  output  1  high in BEEP_ON or BEEP_OFF
- `BurstCount`  output  8  completed bursts in current episode, saturates at 255

## Operation
- Moore FSM, states: IDLE, QUALIFY, BEEP_ON, BEEP_OFF, SILENCED. All outputs registered, decoded from state/counters.
- Reset: state IDLE, `BuzzerOut`=0, `WarningLamp`=0, `ChimeActive`=0, `BurstCount`=0, internal 16-bit phase counter and qualify counter = 0.
- IDLE: `CarAlarmSignal`=1 -> QUALIFY, qualify count=1 (if `DEBOUNCE_CYCLES`=1, go directly to BEEP_ON).
- QUALIFY: `CarAlarmSignal`=0 -> IDLE, count cleared. High with count == `DEBOUNCE_CYCLES`-1 -> BEEP_ON, phase counter=0; else count+1. `AckButton` ignored.
- BEEP_ON: phase counter increments; at `ON_CYCLES`-1 -> BEEP_OFF, counter=0.
- BEEP_OFF: at `OFF_CYCLES`-1 -> `BurstCount`+1 (saturating), then BEEP_ON (or SILENCED, see Configuration).
- In BEEP_ON/BEEP_OFF: `CarAlarmSignal`=0 -> IDLE (highest priority); else `AckButton`=1 -> SILENCED; else normal sequencing.
- SILENCED: `BuzzerOut`=0, `WarningLamp`=1; `CarAlarmSignal`=0 -> IDLE. `AckButton` ignored.
- Entering IDLE clears `BurstCount`; entering BEEP_ON from QUALIFY starts at `BurstCount`=0.
- Output decode: `BuzzerOut`=BEEP_ON; `ChimeActive`=BEEP_ON|BEEP_OFF; `WarningLamp`=BEEP_ON|BEEP_OFF|SILENCED.

## Timing
- `CarAlarmSignal` first sampled high at edge 0 and held: `BuzzerOut` rises after edge `DEBOUNCE_CYCLES`-1 (default: after edge 3).
- Each burst: `BuzzerOut` high exactly `ON_CYCLES` cycles, low exactly `OFF_CYCLES` cycles; period `ON_CYCLES`+`OFF_CYCLES`.
- `BurstCount` increments on the edge leaving BEEP_OFF.
- Alarm drop or ack sampled at edge n: `BuzzerOut` low after edge n (1-cycle latency), mid-burst truncation allowed.
- Simultaneous `CarAlarmSignal`=0 and `AckButton`=1: IDLE wins.
- `reset` overrides all inputs at any state; outputs at reset values after that edge; qualification restarts from scratch.
- Glitch of `CarAlarmSignal` low for one sample during QUALIFY restarts debounce.

## Configuration
- `CHIME_TIMEOUT_EN` defined: on leaving BEEP_OFF with post-increment `BurstCount` == `MAX_BURSTS`, go SILENCED instead of BEEP_ON (buzzer stops, lamp stays on until alarm clears).
- Not defined: `MAX_BURSTS` unused; chiming continues indefinitely while alarm held and not acknowledged; `BurstCount` saturates at 255.

## Test plan
- Reset mid-BEEP_ON (defaults) -> next cycle all outputs 0, `BurstCount`=0; alarm still high -> `BuzzerOut` rises again 4 samples later.
- Alarm high 3 cycles, low 1, high held -> no `BuzzerOut` until 4 consecutive high samples after the gap.
- Alarm held, defaults, no ack -> `BuzzerOut` 8 high/8 low pattern; `BurstCount` 1,2,3… at each off-phase end; with `CHIME_TIMEOUT_EN`, after 6th burst `BuzzerOut`=0, `WarningLamp`=1, `ChimeActive`=0; without it, burst 7 starts.
- `AckButton` pulse during BEEP_ON burst 2 -> `BuzzerOut` low next cycle, `WarningLamp`=1, `BurstCount`=1; alarm later dropped -> all outputs 0.
- `AckButton`=1 and `CarAlarmSignal`=0 on same edge in BEEP_OFF -> IDLE, `WarningLamp`=0, `BurstCount`=0.
- `DEBOUNCE_CYCLES`=1, `ON_CYCLES`=1, `OFF_CYCLES`=1 -> `BuzzerOut` high after first high sample, then toggles every cycle.
